// File: rtl/nn_pkg.sv
// Shared neural-net datapath widths and sequencer state encodings.
package nn_pkg;

  localparam int NN_DATA_W = 8;
  localparam int NN_ACC_W  = 21;
  localparam int NN_OUT_W  = 8;
  localparam int NN_ADDR_W = 6;

  localparam logic [NN_OUT_W-1:0] NN_OUT_MAX = 8'd127;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_OUT    = 3'd5
  } nn_state_e;

endpackage

// File: rtl/relu_sat.sv
// Activation: ReLU on the accumulated sum, fixed-point right shift, saturate to 127.
module relu_sat
  import nn_pkg::*;
#(
  parameter int ACC_W      = NN_ACC_W,
  parameter int FRAC_SHIFT = 7
) (
  input  logic signed [ACC_W-1:0]    sum_i,
  output logic        [NN_OUT_W-1:0] act_o
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-NN_OUT_W){1'b0}}, NN_OUT_MAX};

  logic signed [ACC_W-1:0] shifted_s;

  // Negative sums clamp to zero; positive sums are scaled then clipped.
  always_comb begin
    shifted_s = sum_i >>> FRAC_SHIFT;
    if (sum_i[ACC_W-1]) begin
      act_o = {NN_OUT_W{1'b0}};
    end else if (shifted_s > SAT_MAX) begin
      act_o = NN_OUT_MAX;
    end else begin
      act_o = shifted_s[NN_OUT_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Sequences one neuron evaluation: clears the external accumulator, streams
// N_INPUTS products into it, then presents the activated result on a handshake.
module neuron_sequencer
  import nn_pkg::*;
#(
  parameter int N_INPUTS   = 62,
  parameter int DATA_W     = NN_DATA_W,
  parameter int ACC_W      = NN_ACC_W,
  parameter int FRAC_SHIFT = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [NN_ADDR_W-1:0]     addr,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic signed [DATA_W-1:0] w_data,
  output logic                     acc_init,
  output logic                     acc_load_en,
  output logic signed [ACC_W-1:0]  acc_data,
  input  logic signed [ACC_W-1:0]  acc_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NN_OUT_W-1:0]      out_data
);

  localparam logic [NN_ADDR_W-1:0] LAST_ADDR = NN_ADDR_W'(N_INPUTS - 1);

  nn_state_e                 state_q;
  logic [NN_ADDR_W-1:0]      addr_q;
  logic                      busy_q;
  logic                      acc_init_q;
  logic                      load_q;
  logic                      out_valid_q;
  logic [NN_OUT_W-1:0]       out_data_q;
  logic [NN_OUT_W-1:0]       act_s;
  logic signed [2*DATA_W-1:0] prod_s;

  relu_sat #(
    .ACC_W      (ACC_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_relu_sat (
    .sum_i (acc_sum),
    .act_o (act_s)
  );

  // Memory data lags addr by one cycle, so the load strobe trails RUN by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= {NN_ADDR_W{1'b0}};
      busy_q      <= 1'b0;
      acc_init_q  <= 1'b0;
      load_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {NN_OUT_W{1'b0}};
    end else begin
      acc_init_q <= 1'b0;
      load_q     <= (state_q == ST_RUN);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_INIT;
            busy_q     <= 1'b1;
            acc_init_q <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
          end
        end
        ST_INIT: begin
          state_q <= ST_RUN;
          addr_q  <= {NN_ADDR_W{1'b0}};
        end
        ST_RUN: begin
          if (addr_q == LAST_ADDR) begin
            state_q <= ST_DRAIN;
            addr_q  <= {NN_ADDR_W{1'b0}};
          end else begin
            addr_q  <= addr_q + 6'd1;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_SETTLE;
        end
        // acc_sum now includes the final product added at the end of DRAIN.
        ST_SETTLE: begin
          out_data_q  <= act_s;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            state_q     <= ST_OUT;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          addr_q      <= {NN_ADDR_W{1'b0}};
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign prod_s      = x_data * w_data;
  assign acc_data    = load_q ? {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s}
                              : {ACC_W{1'b0}};
  assign addr        = addr_q;
  assign busy        = busy_q;
  assign acc_init    = acc_init_q;
  assign acc_load_en = load_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  // Handshake completes in the same cycle the consumer accepts.
  assign done        = out_valid_q & out_ready;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Scoreboard bench: two sequencers (FRAC_SHIFT 0 and 7) sharing one 4-entry
// x/w memory, each driving its own accumulator.
module tb_neuron_sequencer;
  import nn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic signed [7:0] x_data, w_data;
  logic signed [7:0] xm [4];
  logic signed [7:0] wm [4];

  logic busy0, done0, init0, load0, ov0;
  logic busy7, done7, init7, load7, ov7;
  logic [5:0] addr0, addr7;
  logic [7:0] od0, od7;
  logic signed [20:0] accd0, accd7, sum0, sum7;

  logic [7:0] q0 [$];
  logic [7:0] q7 [$];
  int n_cmp = 0, n_err = 0, cyc = 0;
  int load_cnt = 0, init_cnt = 0, done_cnt = 0;

  neuron_sequencer #(.N_INPUTS(4), .FRAC_SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0), .addr(addr0),
    .x_data(x_data), .w_data(w_data), .acc_init(init0), .acc_load_en(load0),
    .acc_data(accd0), .acc_sum(sum0), .out_valid(ov0), .out_ready(out_ready), .out_data(od0));

  neuron_sequencer #(.N_INPUTS(4), .FRAC_SHIFT(7)) u_dut7 (
    .clk(clk), .rst(rst), .start(start), .busy(busy7), .done(done7), .addr(addr7),
    .x_data(x_data), .w_data(w_data), .acc_init(init7), .acc_load_en(load7),
    .acc_data(accd7), .acc_sum(sum7), .out_valid(ov7), .out_ready(out_ready), .out_data(od7));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    x_data <= xm[addr0[1:0]];
    w_data <= wm[addr0[1:0]];
  end

  // Accumulators deliberately have no reset: only acc_init clears them.
  always @(posedge clk) begin
    if (init0) sum0 <= 21'sd0;
    else if (load0) sum0 <= sum0 + accd0;
    if (init7) sum7 <= 21'sd0;
    else if (load7) sum7 <= sum7 + accd7;
  end

  always @(posedge clk) begin
    if (load0) load_cnt <= load_cnt + 1;
    if (init0) init_cnt <= init_cnt + 1;
    if (done0) done_cnt <= done_cnt + 1;
  end

  function automatic logic [7:0] act(input int s, input int sh);
    int v;
    if (s < 0) return 8'd0;
    v = s >>> sh;
    if (v > 127) return 8'd127;
    return 8'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_mem(input int x0, x1, x2, x3, w0, w1, w2, w3);
    xm[0] = 8'(x0); xm[1] = 8'(x1); xm[2] = 8'(x2); xm[3] = 8'(x3);
    wm[0] = 8'(w0); wm[1] = 8'(w1); wm[2] = 8'(w2); wm[3] = 8'(w3);
  endtask

  task automatic set_data(input int x0, x1, x2, x3, w0, w1, w2, w3);
    int s;
    set_mem(x0, x1, x2, x3, w0, w1, w2, w3);
    s = x0 * w0 + x1 * w1 + x2 * w2 + x3 * w3;
    q0.push_back(act(s, 0));
    q7.push_back(act(s, 7));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (ov0 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done0 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++;
    if ({busy0, done0, addr0, init0, load0, ov0, od0, accd0} !== 40'd0) begin
      n_err++;
      $display("FAIL reset_dut0: got busy=%b done=%b addr=%0d init=%b load=%b ov=%b od=%0d acc_data=%0d required all 0",
               busy0, done0, addr0, init0, load0, ov0, od0, accd0);
    end
    n_cmp++;
    if ({busy7, done7, addr7, init7, load7, ov7, od7} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_dut7: got busy=%b addr=%0d ov=%b od=%0d required all 0", busy7, addr7, ov7, od7);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lc, ic;
    logic [5:0] addr_exp [6];
    logic [7:0] e0, e7;
    addr_exp = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd0, 6'd0};
    set_data(1, 2, 3, 4, 1, 1, 1, 1);
    lc = load_cnt;
    ic = init_cnt;
    pulse_start();
    n_cmp++;
    if (init0 !== 1'b1 || busy0 !== 1'b1) begin
      n_err++;
      $display("FAIL basic_init: got init=%b busy=%b required 1 1", init0, busy0);
    end
    for (int s = 0; s < 6; s++) begin
      step();
      n_cmp++;
      if (addr0 !== addr_exp[s] || ov0 !== 1'b0 || init0 !== 1'b0) begin
        n_err++;
        $display("FAIL basic_addr[%0d]: got addr=%0d ov=%b init=%b required addr=%0d ov=0 init=0",
                 s, addr0, ov0, init0, addr_exp[s]);
      end
    end
    step();
    n_cmp++;
    if (ov0 !== 1'b1 || done0 !== 1'b1) begin
      n_err++;
      $display("FAIL basic_valid_cycle8: got ov=%b done=%b required 1 1", ov0, done0);
    end
    e0 = q0.pop_front();
    e7 = q7.pop_front();
    n_cmp++;
    if (od0 !== e0 || od7 !== e7) begin
      n_err++;
      $display("FAIL basic_data: got %0d/%0d required %0d/%0d", od0, od7, e0, e7);
    end
    step();
    n_cmp++;
    if (load_cnt - lc !== 4 || init_cnt - ic !== 1 || busy0 !== 1'b0 || ov0 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_pulses: got loads=%0d inits=%0d busy=%b ov=%b required 4 1 0 0",
               load_cnt - lc, init_cnt - ic, busy0, ov0);
    end
  endtask

  task automatic test_negative();
    int n;
    logic [7:0] e0, e7;
    set_data(1, 2, 3, 4, -1, -1, -1, -1);
    pulse_start();
    wait_valid(n);
    e0 = q0.pop_front();
    e7 = q7.pop_front();
    n_cmp++;
    if (n >= 40 || sum0 !== -21'sd10) begin
      n_err++;
      $display("FAIL neg_sum: got acc_sum=%0d waited=%0d required -10", sum0, n);
    end
    n_cmp++;
    if (od0 !== e0 || od7 !== e7) begin
      n_err++;
      $display("FAIL neg_data: got %0d/%0d required %0d/%0d", od0, od7, e0, e7);
    end
    step();
  endtask

  task automatic test_saturate();
    int n;
    logic [7:0] e0, e7;
    set_data(127, 127, 127, 127, 127, 127, 127, 127);
    pulse_start();
    wait_valid(n);
    e0 = q0.pop_front();
    e7 = q7.pop_front();
    n_cmp++;
    if (n >= 40 || sum7 !== 21'sd64516) begin
      n_err++;
      $display("FAIL sat_sum: got acc_sum=%0d waited=%0d required 64516", sum7, n);
    end
    n_cmp++;
    if (od7 !== e7 || od0 !== e0) begin
      n_err++;
      $display("FAIL sat_data: got %0d/%0d required %0d/%0d", od7, od0, e7, e0);
    end
    step();
  endtask

  task automatic test_backpressure();
    int n, dc;
    logic [7:0] e0, e7;
    out_ready = 1'b0;
    set_data(100, 50, 25, -10, 2, 2, 2, 2);
    pulse_start();
    wait_valid(n);
    e0 = q0.pop_front();
    e7 = q7.pop_front();
    dc = done_cnt;
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      n_cmp++;
      if (n >= 40 || ov0 !== 1'b1 || od0 !== e0 || od7 !== e7 || busy0 !== 1'b1 || done0 !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got ov=%b od=%0d/%0d busy=%b done=%b required 1 %0d/%0d 1 0",
                 i, ov0, od0, od7, busy0, done0, e0, e7);
      end
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (done0 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_done: got %b required 1", done0);
    end
    step();
    step();
    n_cmp++;
    if (busy0 !== 1'b0 || ov0 !== 1'b0 || done_cnt - dc !== 1) begin
      n_err++;
      $display("FAIL bp_after: got busy=%b ov=%b dones=%0d required 0 0 1", busy0, ov0, done_cnt - dc);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic [7:0] e0, e7;
    set_mem(127, 127, 127, 127, 127, 127, 127, 127);
    pulse_start();
    step();
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy0, done0, addr0, init0, load0, ov0, od0} !== 19'd0) begin
      n_err++;
      $display("FAIL midrst_outputs: got busy=%b done=%b addr=%0d init=%b load=%b ov=%b od=%0d required all 0",
               busy0, done0, addr0, init0, load0, ov0, od0);
    end
    step();
    rst = 1'b0;
    step();
    set_data(1, 2, 3, 4, 1, 1, 1, 1);
    pulse_start();
    wait_valid(n);
    e0 = q0.pop_front();
    e7 = q7.pop_front();
    n_cmp++;
    if (n >= 40 || od0 !== e0 || od7 !== e7 || od0 !== 8'd10) begin
      n_err++;
      $display("FAIL midrst_rerun: got %0d/%0d required %0d/%0d", od0, od7, e0, e7);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n, t1, t2;
    logic [7:0] e0, e7;
    set_data(5, 6, 7, 8, 1, 2, 3, -1);
    start = 1'b1;
    wait_done(n);
    t1 = cyc;
    e0 = q0.pop_front();
    e7 = q7.pop_front();
    n_cmp++;
    if (n >= 40 || od0 !== e0 || od7 !== e7) begin
      n_err++;
      $display("FAIL b2b_first: got %0d/%0d required %0d/%0d", od0, od7, e0, e7);
    end
    set_data(60, 60, 60, 60, 1, 1, 1, 1);
    step();
    wait_done(n);
    t2 = cyc;
    start = 1'b0;
    e0 = q0.pop_front();
    e7 = q7.pop_front();
    n_cmp++;
    if (n >= 40 || od0 !== e0 || od7 !== e7) begin
      n_err++;
      $display("FAIL b2b_second: got %0d/%0d required %0d/%0d", od0, od7, e0, e7);
    end
    n_cmp++;
    if (t2 - t1 !== 9) begin
      n_err++;
      $display("FAIL b2b_gap: got %0d cycles required 9", t2 - t1);
    end
    step();
    step();
    n_cmp++;
    if (busy0 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: got busy=%b required 0", busy0);
    end
  endtask

  initial begin
    set_mem(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_negative();
    test_saturate();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 SHALL have parameter N_INPUTS, default 62, meaning products summed per neuron (2..63).
REQ-002 SHALL have parameter DATA_W, default 8, meaning signed width of input/weight operands.
REQ-003 SHALL have parameter ACC_W, default 21, meaning width of the accumulator data path.
REQ-004 SHALL have parameter FRAC_SHIFT, default 7, meaning right shift applied to a positive sum before saturation.
REQ-005 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  request one neuron evaluation, sampled only in IDLE.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse on output handshake.
REQ-010 SHALL have port addr  output  6  shared x/w memory read address, 0..N_INPUTS-1.
REQ-011 SHALL have ports x_data, w_data  input  DATA_W each  signed operands, valid one cycle after addr.
REQ-012 SHALL have port acc_init  output  1  clears external accumulator.
REQ-013 SHALL have port acc_load_en  output  1  accumulator adds acc_data this edge.
REQ-014 SHALL have port acc_data  output  ACC_W  x_data*w_data, signed 16-bit product sign-extended to ACC_W.
REQ-015 SHALL have port acc_sum  input  ACC_W  signed accumulator register value.
REQ-016 SHALL have ports out_valid  output  1, out_ready  input  1, out_data  output  8  activated neuron result.

Function
REQ-017 SHALL implement FSM states IDLE, INIT, RUN, DRAIN, SETTLE, OUT.
REQ-018 SHALL transition IDLE->INIT when start=1; start in any other state SHALL be ignored.
REQ-019 SHALL assert acc_init for exactly the single INIT cycle, then enter RUN.
REQ-020 SHALL in RUN drive addr = counter, counting 0..N_INPUTS-1 one per cycle; after addr N_INPUTS-1 enter DRAIN.
REQ-021 SHALL assert acc_load_en registered one cycle after each RUN cycle (exactly N_INPUTS pulses, last during DRAIN).
REQ-022 SHALL compute acc_data combinationally from x_data, w_data whenever acc_load_en=1.
REQ-023 SHALL spend one SETTLE cycle, capturing out_data from acc_sum at its end, then enter OUT.
REQ-024 SHALL compute out_data: acc_sum<0 -> 0; else (acc_sum >>> FRAC_SHIFT) saturated to 127.
REQ-025 SHALL hold out_valid=1 and out_data stable in OUT until out_ready=1; that cycle pulses done and returns to IDLE.
REQ-026 SHALL, for start sampled at cycle 0, assert out_valid first at cycle N_INPUTS+4.
REQ-027 SHALL leave addr at 0 and acc_load_en, acc_init at 0 outside their defined cycles.
REQ-028 SHALL, with start held high, begin a new evaluation one cycle after the handshake (via IDLE).

Reset
REQ-029 SHALL on rst force state IDLE, counter 0, addr 0, busy 0, done 0, acc_init 0, acc_load_en 0, out_valid 0, out_data 0.
REQ-030 SHALL, on rst mid-operation, abandon the evaluation; the next INIT clears stale accumulator contents.

Structure
REQ-031 SHALL take DATA_W, ACC_W, output width 8, and FSM state encodings from the shared nn_pkg package.
REQ-032 SHALL place activation (ReLU, shift, saturate) in a combinational sub-module relu_sat.
REQ-033 SHALL NOT contain the accumulator; the bench and top level connect the existing accumulator to acc_* ports.

Verification (N_INPUTS=4, bench connects accumulator)
REQ-034 x=[1,2,3,4], w=[1,1,1,1], FRAC_SHIFT=0 -> 4 load pulses, out_data=10, out_valid at cycle 8.
REQ-035 x=[1,2,3,4], w=[-1,-1,-1,-1] -> acc_sum=-10, out_data=0.
REQ-036 x=w=127 all four, FRAC_SHIFT=7 -> sum 64516, 504 saturates, out_data=127.
REQ-037 out_ready low 5 cycles in OUT, start pulsed -> out_valid, out_data stable, busy=1, start ignored, single done.
REQ-038 rst asserted during second RUN cycle -> all outputs reset at once; new start with REQ-034 data -> out_data=10.
REQ-039 start held high, two evaluations with different data -> two correct results, done pulses N_INPUTS+5 cycles apart with out_ready=1.
